// File: rtl/spi_slave_port.sv
// SPI slave endpoint: LSB-first MOSI bytes into a small receive FIFO, MSB-first
// MISO bytes from a transmit holding register. Everything runs on sclk.
//
// state | meaning
// IDLE  | cs_bar high; a full holding register may preload tx_shift
// SHIFT | cs_bar low; bit_cnt tracks posedges 0..7 of the current byte
module spi_slave_port #(
  parameter int RX_DEPTH = 4
) (
  input  logic       sclk,
  input  logic       reset,
  input  logic       cs_bar,
  input  logic       mosi,
  output logic       miso,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       rx_overflow,
  output logic       tx_underrun,
  output logic       frame_abort
);
  localparam int AW = $clog2(RX_DEPTH);

  typedef enum logic {IDLE, SHIFT} state_t;
  state_t state;

  logic [2:0]  bit_cnt;
  logic [7:0]  rx_shift;
  logic [7:0]  tx_shift;
  logic [7:0]  tx_hold;
  logic        hold_full;
  logic        tx_loaded;
  logic        miso_q;
  logic [7:0]  fifo_mem [RX_DEPTH];
  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;

  logic       byte_done;
  logic       fifo_full;
  logic       pop;
  logic       push_ok;
  logic       accept;
  logic       idle_load;
  logic       abort;
  logic [7:0] rx_byte;

  assign byte_done = !cs_bar && (bit_cnt == 3'd7);
  assign rx_byte   = {mosi, rx_shift[7:1]};
  assign fifo_full = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign rx_valid  = (wr_ptr != rd_ptr);
  assign rx_data   = fifo_mem[rd_ptr[AW-1:0]];
  assign pop       = rx_valid && rx_ready;
  // a pop in the same cycle frees the slot the push needs
  assign push_ok   = byte_done && (!fifo_full || pop);
  assign tx_ready  = !hold_full;
  assign accept    = tx_valid && !hold_full;
  assign idle_load = cs_bar && hold_full && !tx_loaded;
  assign abort     = cs_bar && (state == SHIFT) && (bit_cnt != 3'd0);
  assign miso      = miso_q && !cs_bar;

  always_ff @(posedge sclk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      bit_cnt     <= 3'd0;
      rx_shift    <= 8'h00;
      tx_shift    <= 8'h00;
      tx_hold     <= 8'h00;
      hold_full   <= 1'b0;
      tx_loaded   <= 1'b0;
      rx_overflow <= 1'b0;
      tx_underrun <= 1'b0;
      frame_abort <= 1'b0;
    end else begin
      frame_abort <= 1'b0;
      if (cs_bar) begin
        state <= IDLE;
        if (abort) begin
          frame_abort <= 1'b1;
          bit_cnt     <= 3'd0;
          rx_shift    <= 8'h00;
          tx_shift    <= 8'h00;
          tx_loaded   <= 1'b0;
        end else if (idle_load) begin
          tx_shift  <= tx_hold;
          tx_loaded <= 1'b1;
          hold_full <= 1'b0;
        end
      end else begin
        state    <= SHIFT;
        rx_shift <= rx_byte;
        bit_cnt  <= bit_cnt + 3'd1;
        if (bit_cnt == 3'd7) begin
          if (hold_full) begin
            tx_shift  <= tx_hold;
            tx_loaded <= 1'b1;
            hold_full <= 1'b0;
          end else begin
            tx_shift    <= 8'h00;
            tx_loaded   <= 1'b0;
            tx_underrun <= 1'b1;
          end
          if (!push_ok) rx_overflow <= 1'b1;
        end else begin
          tx_shift <= {tx_shift[6:0], 1'b0};
        end
      end
      // acceptance wins over a same-cycle load so the new byte is kept
      if (accept) begin
        tx_hold   <= tx_data;
        hold_full <= 1'b1;
      end
    end
  end

  always_ff @(posedge sclk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      for (int i = 0; i < RX_DEPTH; i++) fifo_mem[i] <= 8'h00;
    end else begin
      if (push_ok) begin
        fifo_mem[wr_ptr[AW-1:0]] <= rx_byte;
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(negedge sclk or posedge reset) begin
    if (reset) miso_q <= 1'b0;
    else       miso_q <= cs_bar ? 1'b0 : tx_shift[7];
  end
endmodule

// File: tb/tb_spi_slave_port.sv
// Bench for spi_slave_port: table-driven full-duplex frames plus hand-written
// overflow, underrun, abort and mid-byte reset sequences against byte queues.
module tb_spi_slave_port;
  localparam int RX_DEPTH = 4;

  logic       sclk = 1'b0;
  logic       reset = 1'b1;
  logic       cs_bar = 1'b1;
  logic       mosi = 1'b0;
  logic       miso;
  logic [7:0] tx_data = 8'h00;
  logic       tx_valid = 1'b0;
  logic       tx_ready;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready = 1'b0;
  logic       rx_overflow;
  logic       tx_underrun;
  logic       frame_abort;

  int checks = 0;
  int errors = 0;

  logic [7:0] rx_q [$];
  logic [7:0] tx_q [$];
  logic       ov_exp = 1'b0;
  logic       un_exp = 1'b0;
  logic       hold_exp = 1'b0;

  typedef struct {
    logic [7:0] mosi_byte;
    logic [7:0] tx_byte;
  } vec_t;
  vec_t vecs [6];

  spi_slave_port #(.RX_DEPTH(RX_DEPTH)) dut (
    .sclk(sclk), .reset(reset), .cs_bar(cs_bar), .mosi(mosi), .miso(miso),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .rx_overflow(rx_overflow), .tx_underrun(tx_underrun), .frame_abort(frame_abort)
  );

  always #5 sclk = ~sclk;

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached, got no finish, expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%02h expected 0x%02h", name, act, exp);
    end
  endtask

  task automatic check1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1; cs_bar = 1'b1; mosi = 1'b0; tx_valid = 1'b0; rx_ready = 1'b0;
    rx_q.delete(); tx_q.delete();
    ov_exp = 1'b0; un_exp = 1'b0; hold_exp = 1'b0;
    @(posedge sclk); #1 reset = 1'b0;
    @(posedge sclk); #1;
  endtask

  // one master bit: drive, sample miso before the sampling posedge
  task automatic bit_cycle(input logic m, output logic s);
    cs_bar = 1'b0; mosi = m;
    @(negedge sclk); #1 s = miso;
    @(posedge sclk); #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic pop7, input logic offer,
                           input logic [7:0] txb, output logic [7:0] mb);
    logic       s;
    logic [7:0] acc;
    acc = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (i == 0 && offer) begin
        tx_data = txb; tx_valid = 1'b1; tx_q.push_back(txb); hold_exp = 1'b1;
      end
      if (i == 7 && pop7) begin
        check("rx_head_at_pop", rx_data, rx_q[0]);
        rx_ready = 1'b1;
        void'(rx_q.pop_front());
      end
      bit_cycle(b[i], s);
      acc = {acc[6:0], s};
      tx_valid = 1'b0; rx_ready = 1'b0;
    end
    if (rx_q.size() < RX_DEPTH) rx_q.push_back(b);
    else ov_exp = 1'b1;
    if (hold_exp) hold_exp = 1'b0;
    else begin
      un_exp = 1'b1;
      tx_q.push_back(8'h00);
    end
    mb = acc;
  endtask

  task automatic preload(input logic [7:0] b);
    tx_data = b; tx_valid = 1'b1; tx_q.push_back(b);
    @(posedge sclk); #1 tx_valid = 1'b0;
    check1("tx_ready_after_accept", tx_ready, 1'b0);
    @(posedge sclk); #1;
    check1("tx_ready_after_idle_load", tx_ready, 1'b1);
  endtask

  task automatic check_status(input string tag);
    check1({tag, "_rx_valid"}, rx_valid, rx_q.size() != 0);
    if (rx_q.size() != 0) check({tag, "_rx_data"}, rx_data, rx_q[0]);
    check1({tag, "_rx_overflow"}, rx_overflow, ov_exp);
    check1({tag, "_tx_underrun"}, tx_underrun, un_exp);
    check1({tag, "_tx_ready"}, tx_ready, !hold_exp);
    check1({tag, "_frame_abort"}, frame_abort, 1'b0);
  endtask

  task automatic pop_one(input string tag);
    check1({tag, "_rx_valid"}, rx_valid, 1'b1);
    check({tag, "_rx_data"}, rx_data, rx_q[0]);
    rx_ready = 1'b1;
    void'(rx_q.pop_front());
    @(posedge sclk); #1 rx_ready = 1'b0;
  endtask

  task automatic drain(input string tag);
    cs_bar = 1'b1;
    while (rx_q.size() != 0) pop_one(tag);
    check1({tag, "_empty"}, rx_valid, 1'b0);
  endtask

  initial begin
    logic [7:0] mb;
    logic       s;

    vecs[0] = '{8'hA5, 8'h3C};
    vecs[1] = '{8'h01, 8'h81};
    vecs[2] = '{8'hFF, 8'h00};
    vecs[3] = '{8'h5A, 8'hC3};
    vecs[4] = '{8'h80, 8'h7E};
    vecs[5] = '{8'h3C, 8'hA5};

    // reset values
    do_reset();
    check1("rst_miso", miso, 1'b0);
    check1("rst_tx_ready", tx_ready, 1'b1);
    check1("rst_rx_valid", rx_valid, 1'b0);
    check("rst_rx_data", rx_data, 8'h00);
    check1("rst_rx_overflow", rx_overflow, 1'b0);
    check1("rst_tx_underrun", tx_underrun, 1'b0);
    check1("rst_frame_abort", frame_abort, 1'b0);

    // table-driven full-duplex frame, back-to-back bytes
    preload(vecs[0].tx_byte);
    for (int k = 0; k < 6; k++) begin
      send_byte(vecs[k].mosi_byte, k > 0, k < 5, (k < 5) ? vecs[k + 1].tx_byte : 8'h00, mb);
      check($sformatf("vec%0d_miso_byte", k), mb, tx_q.pop_front());
      check_status($sformatf("vec%0d", k));
    end
    drain("vec_drain");

    // single preloaded byte then underrun
    do_reset();
    preload(8'h81);
    send_byte(8'h00, 1'b0, 1'b0, 8'h00, mb);
    check("un_first_byte", mb, tx_q.pop_front());
    send_byte(8'h00, 1'b0, 1'b0, 8'h00, mb);
    check("un_second_byte", mb, tx_q.pop_front());
    check1("un_sticky", tx_underrun, 1'b1);
    check_status("un");

    // overflow with rx_ready held low
    do_reset();
    for (int v = 1; v <= 5; v++) begin
      send_byte(8'(v), 1'b0, 1'b0, 8'h00, mb);
      check_status($sformatf("ov%0d", v));
    end
    check1("ov_sticky", rx_overflow, 1'b1);
    drain("ov_drain");
    check1("ov_stays_after_drain", rx_overflow, 1'b1);

    // push and pop on the same edge with the FIFO full
    do_reset();
    for (int v = 1; v <= 4; v++) send_byte(8'(v * 17), 1'b0, 1'b0, 8'h00, mb);
    send_byte(8'h55, 1'b1, 1'b0, 8'h00, mb);
    check_status("full_pushpop");
    drain("full_pushpop_drain");

    // frame abort after three bits
    do_reset();
    for (int i = 0; i < 3; i++) bit_cycle(1'b1, s);
    check1("abort_before", frame_abort, 1'b0);
    cs_bar = 1'b1;
    @(posedge sclk); #1;
    check1("abort_pulse", frame_abort, 1'b1);
    check1("abort_no_push", rx_valid, 1'b0);
    @(posedge sclk); #1;
    check1("abort_pulse_end", frame_abort, 1'b0);
    send_byte(8'h5A, 1'b0, 1'b0, 8'h00, mb);
    check_status("abort_next");
    drain("abort_drain");

    // asynchronous reset five bits into the third byte
    do_reset();
    send_byte(8'h11, 1'b0, 1'b0, 8'h00, mb);
    send_byte(8'h22, 1'b0, 1'b1, 8'hFF, mb);
    tx_data = 8'h55; tx_valid = 1'b1;
    bit_cycle(1'b1, s);
    tx_valid = 1'b0;
    for (int i = 0; i < 4; i++) bit_cycle(1'b0, s);
    check1("pre_rst_miso", miso, 1'b1);
    check1("pre_rst_tx_ready", tx_ready, 1'b0);
    check1("pre_rst_underrun", tx_underrun, 1'b1);
    check1("pre_rst_rx_valid", rx_valid, 1'b1);
    reset = 1'b1; cs_bar = 1'b1;
    #1;
    check1("mid_rst_rx_valid", rx_valid, 1'b0);
    check1("mid_rst_tx_ready", tx_ready, 1'b1);
    check1("mid_rst_miso", miso, 1'b0);
    check1("mid_rst_underrun", tx_underrun, 1'b0);
    check1("mid_rst_overflow", rx_overflow, 1'b0);
    check1("mid_rst_abort", frame_abort, 1'b0);
    rx_q.delete(); tx_q.delete();
    ov_exp = 1'b0; un_exp = 1'b0; hold_exp = 1'b0;
    @(posedge sclk); #1 reset = 1'b0;
    send_byte(8'h96, 1'b0, 1'b0, 8'h00, mb);
    check_status("post_rst");
    drain("post_rst_drain");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/spi_slave_port.md
# spi_slave_port

Mode-agnostic SPI slave endpoint that terminates one chip-select line of the SPI master (`CS1bar`/`CS2bar`/`CS3bar`). It deserialises LSB-first MOSI bytes into a small receive FIFO and serialises MSB-first bytes from a transmit holding register onto MISO. Its parallel side runs entirely in the `sclk` domain and uses valid/ready handshakes. Polarity handling stays in the master: `sclk` arrives already adjusted for MODE, so this block always samples on the rising edge and drives on the falling edge.

## Interface

Parameters:
- `RX_DEPTH`, default 4: receive FIFO depth in bytes. Must be a power of 2 and at least 2.

Ports (name, direction, width, meaning):
- `sclk` in 1: SPI clock from the master; all state is clocked on it.
- `reset` in 1: asynchronous, active-high; connect to the master `sreset`.
- `cs_bar` in 1: active-low chip select.
- `mosi` in 1: serial data from the master, LSB first.
- `miso` out 1: serial data to the master, MSB first.
- `tx_data` in 8: byte to return to the master.
- `tx_valid` in 1: `tx_data` is valid.
- `tx_ready` out 1: transmit holding register is empty.
- `rx_data` out 8: head of the receive FIFO.
- `rx_valid` out 1: receive FIFO is not empty.
- `rx_ready` in 1: consumer pops the FIFO head.
- `rx_overflow` out 1: sticky; a byte was dropped because the FIFO was full.
- `tx_underrun` out 1: sticky; a byte slot began with the holding register empty.
- `frame_abort` out 1: one-cycle pulse when `cs_bar` rises mid-byte.

## Operation

- **States:**
  - IDLE: `cs_bar`=1.
  - SHIFT: `cs_bar`=0. `bit_cnt` (3 bits) counts posedges 0..7.
- **RX path:**
  - On each SHIFT posedge: `rx_shift <= {mosi, rx_shift[7:1]}` (LSB-first assembly).
  - When `bit_cnt`==7, the assembled byte `{mosi, rx_shift[7:1]}` is pushed to the FIFO and `bit_cnt` wraps to 0.
  - Push with the FIFO full: the byte is dropped and `rx_overflow` is set. FIFO contents are unchanged.
  - Pop when `rx_valid & rx_ready` at a posedge.
  - Push and pop in the same cycle on a full FIFO: the pop frees the slot and the push succeeds, with no overflow.
- **TX path:**
  - The holding register accepts `tx_data` when `tx_valid & tx_ready` at a posedge.
  - `tx_shift` is loaded from the holding register (clearing it) in two cases:
    - at any IDLE posedge while the holding register is full and `tx_loaded`=0;
    - at the SHIFT posedge where `bit_cnt`==7.
  - If the holding register is empty at a `bit_cnt`==7 posedge: `tx_shift` loads 0x00 and `tx_underrun` is set.
  - Acceptance and load in the same cycle: the new byte enters the holding register, the old byte enters `tx_shift`, and `tx_ready` stays 0.
  - On each SHIFT posedge with `bit_cnt`≠7: `tx_shift <= {tx_shift[6:0], 1'b0}`.
  - `miso` is a negedge flop capturing `tx_shift[7]` while `cs_bar`=0. It is forced to 0 while `cs_bar`=1.
- **Frame abort:**
  - `cs_bar` rising with `bit_cnt`≠0 discards the partial byte, clears `bit_cnt`, and pulses `frame_abort` on the next posedge.
  - The partially sent `tx_shift` byte is lost and `tx_loaded` is cleared.
  - The FIFO and holding register are unaffected.
- **Reset (asynchronous, any time including mid-byte):**
  - FIFO emptied; holding register emptied.
  - `bit_cnt`=0, `rx_shift`=0, `tx_shift`=0.
  - Sticky flags cleared; state IDLE.

## Timing

- **Reset values:** `miso`=0, `tx_ready`=1, `rx_valid`=0, `rx_data`=0, `rx_overflow`=0, `tx_underrun`=0, `frame_abort`=0.
- **RX latency:** `rx_valid` rises at the same posedge that samples bit 7. `rx_data` reflects the FIFO head combinationally from the read pointer.
- **TX bit order:** a byte in `tx_shift` appears on `miso` MSB first, one bit per negedge. The master samples each bit on the following posedge. Bit 7 is valid before the first SHIFT posedge.
- **`tx_ready`:** falls at the accepting posedge and rises at the loading posedge.
- **Sticky flags:** remain set until reset.
- **Throughput:** one byte per 8 `sclk` in each direction, with no idle cycles between consecutive bytes while `cs_bar` stays low.

## Test plan

- **Reset, then single receive:** hold `cs_bar`=0 and shift 0xA5 LSB-first (1,0,1,0,0,1,0,1). Required: after 8 posedges `rx_valid`=1, `rx_data`=0xA5, `rx_overflow`=0.
- **Full-duplex transmit:** preload `tx_data`=0x3C in IDLE, then run 8 clocks. Required: master samples `miso` sequence 0,0,1,1,1,1,0,0; `tx_ready` returns to 1; `tx_underrun`=0.
- **Back-to-back with underrun:** load one TX byte 0x81 and run 16 clocks without a second `tx_valid`. Required: second byte on `miso` is 0x00 and `tx_underrun`=1.
- **Overflow:** with `rx_ready`=0, receive 5 bytes 0x01..0x05 at `RX_DEPTH`=4. Required: `rx_overflow`=1, then pops return 0x01, 0x02, 0x03, 0x04 and `rx_valid`=0.
- **Frame abort:** raise `cs_bar` after 3 bits, then send a full byte 0x5A. Required: `frame_abort` pulses once, no partial byte is pushed, and the FIFO holds only 0x5A.
- **Reset mid-byte:** assert `reset` after 5 bits with 2 bytes queued in the FIFO. Required: immediately `rx_valid`=0, `tx_ready`=1, `miso`=0, flags 0; the next full byte is received correctly.
